ctrl_decode_pipe: RTL and testbench
===================================

Name: ctrl_decode_pipe

Overview:
- Registered successor to the ID-stage control decoder.
- Decodes a full 32-bit RV32I instruction, plus RV32M when enabled, into the team's standard EX/MEM/WB control bundle.
- Holds the result in an ID/EX pipeline register with a valid/ready handshake, flush and illegal-instruction flagging.
- Adds a structural-hazard interlock for a multi-cycle mul/div unit.

Parameters:
- ENABLE_M, 1, decode RV32M (funct7=0000001 on OP); when 0 such encodings are illegal.
- MD_LAT, 4, mul/div unit occupancy in cycles (>=1).
- PC_W, 32, width of the PC tag carried alongside the instruction.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  squash the register contents and the current input this cycle
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  registered bundle valid
- out_ready  in  1  EX accepts
- out_pc  out  PC_W  registered PC
- out_rd  out  5  inst[11:7]
- out_ExtOp  out  3  immediate type
- out_Branch  out  3  branch/jump type
- out_ALUBSrc  out  2  ALU B select
- out_ALUctr  out  4  ALU op
- out_MemOp  out  3  memory width/sign
- out_RegWr, out_MemtoReg, out_ALUASrc, out_MemWr  out  1 each
- out_md_en  out  1  mul/div op
- out_md_op  out  3  funct3 of the mul/div op
- out_illegal  out  1  undecodable instruction

Behaviour:
- Fields: op=inst[6:2], f3=inst[14:12], f7=inst[31:25]. If inst[1:0]!=11, the instruction is illegal.
- Decode (any control not listed is 0):
  - LUI 01101: Ext=001, RegWr, ALUB=01, ALUctr=1111.
  - AUIPC 00101: Ext=001, RegWr, ALUA=1, ALUB=01, ALUctr=0000.
  - OP-IMM 00100: Ext=000, RegWr, ALUB=01. ALUctr={f7[5],f3} when f3=101, else {0,f3}.
  - OP 01100: Ext=101, RegWr, ALUB=00, ALUctr={f7[5],f3}.
    - Legal when f7=0000000, or f7=0100000 with f3 in {000,101}.
    - f7=0000001 with ENABLE_M=1: md_en=1, md_op=f3, ALUctr=0000.
  - JAL 11011: Ext=100, RegWr, ALUA=1, ALUB=10, Branch=001.
  - JALR 11001: Ext=000, RegWr, ALUA=1, ALUB=10, Branch=010.
  - BRANCH 11000: Ext=011.
    - Branch by f3: 000→100, 001→101, 100→110, 101→111, 110→110, 111→111; 010/011 illegal.
    - ALUctr=0011 for f3 in {110,111}, else 0010.
  - LOAD 00000: Ext=000, RegWr, MemtoReg, ALUB=01. MemOp by f3: 000→001, 001→010, 010→000, 100→101, 101→110; others illegal.
  - STORE 01000: Ext=010, MemWr, ALUB=01. MemOp by f3: 000→001, 001→010, 010→000; others illegal.
  - Any other op: illegal.
- Illegal instruction: all controls 0 (bubble bundle), out_illegal=1, still delivered with out_valid=1 and out_pc for the trap.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !md_block.
  - Accept = in_valid & in_ready.
  - On accept, the register loads the decoded bundle the next edge; latency 1.
  - If out_valid & !out_ready, every out_* holds stable.
  - On drain without accept, out_valid falls to 0.
  - No combinational path from in_* to out_*.
- Mul/div interlock:
  - Counter md_cnt, width clog2(MD_LAT+1).
  - Accepting an md op loads md_cnt=MD_LAT-1; otherwise it decrements to 0 each cycle.
  - md_block = (md_cnt!=0) & decoded md_en of in_inst. Non-md ops are never blocked.
  - MD_LAT=1 gives no blocking.
- Flush (priority over accept):
  - Next edge: out_valid=0 and md_cnt=0.
  - The input is not accepted that cycle; in_ready is don't-care.
- Reset (rst_n=0 at the edge): out_valid=0, md_cnt=0, all out_* bundle fields=0, out_pc=0. Reset mid-stall discards the held bundle.
- Simultaneous drain and accept: the register reloads in the same edge, sustaining full throughput of 1 instruction/cycle.

Decomposition:
- Shared package holds:
  - Opcode constants: OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE.
  - ExtOp/Branch/MemOp/ALUBSrc encodings.
  - The control-bundle struct.
- One combinational sub-module, ctrl_decode_comb (inst → bundle + illegal + md_en); the top holds the register, handshake and counter.

Test Plan:
- ADDI x1 (0x00500093), out_ready=1 → next cycle out_valid=1, Ext=000, ALUB=01, ALUctr=0000, RegWr=1, illegal=0.
- SRAI (0x4020D093) → ALUctr=1101; BNE (f3=001) → Branch=101, Ext=011, ALUctr=0010; BLTU → Branch=110, ALUctr=0011; LH → MemOp=010, MemtoReg=1.
- LOAD with f3=011 and opcode 0x7F → out_illegal=1, all controls 0, out_valid=1, out_pc preserved.
- MD_LAT=4: MUL then DIV back-to-back → in_ready low 3 cycles for DIV, accepted on the 4th; an ADD presented instead is accepted immediately.
- out_ready=0 for 5 cycles with in_valid=1 → out_* stable, in_ready=0; release → one bundle per cycle, none lost or duplicated.
- flush during a held bundle with md_cnt=2 → next cycle out_valid=0 and a MUL is accepted at once; rst_n=0 mid-stream → all outputs 0 next edge.

Source files
------------

// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared encodings and control bundle for the
// registered ID-stage control decoder.
package ctrl_decode_pipe_pkg;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_COPYB = 4'b1111;

    typedef enum logic [2:0] {
        EXT_I = 3'b000,
        EXT_U = 3'b001,
        EXT_S = 3'b010,
        EXT_B = 3'b011,
        EXT_J = 3'b100,
        EXT_R = 3'b101
    } ext_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_EQ   = 3'b100,
        BR_NE   = 3'b101,
        BR_LT   = 3'b110,
        BR_GE   = 3'b111
    } branch_e;

    typedef enum logic [2:0] {
        MEM_W  = 3'b000,
        MEM_B  = 3'b001,
        MEM_H  = 3'b010,
        MEM_BU = 3'b101,
        MEM_HU = 3'b110
    } mem_op_e;

    typedef enum logic [1:0] {
        ALUB_RS2 = 2'b00,
        ALUB_IMM = 2'b01,
        ALUB_4   = 2'b10
    } alub_src_e;

    typedef struct packed {
        ext_op_e   ext_op;
        branch_e   branch;
        alub_src_e alub_src;
        logic [3:0] alu_ctr;
        mem_op_e   mem_op;
        logic      reg_wr;
        logic      mem_to_reg;
        logic      alua_src;
        logic      mem_wr;
        logic      md_en;
        logic [2:0] md_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational RV32I(+M) instruction to
// EX/MEM/WB control bundle decoder.
module ctrl_decode_comb
    import ctrl_decode_pipe_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] inst_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o,
    output logic        md_en_o
);

    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_bits;

    assign op = inst_i[6:2];
    assign f3 = inst_i[14:12];
    assign f7 = inst_i[31:25];
    assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

    ctrl_t c;
    logic  ill;

    // Decode; any illegal encoding collapses to a bubble bundle
    always_comb begin
        c   = '0;
        ill = 1'b0;
        unique case (op)
            OPC_LUI: begin
                c.ext_op   = EXT_U;
                c.reg_wr   = 1'b1;
                c.alub_src = ALUB_IMM;
                c.alu_ctr  = ALU_COPYB;
            end
            OPC_AUIPC: begin
                c.ext_op   = EXT_U;
                c.reg_wr   = 1'b1;
                c.alua_src = 1'b1;
                c.alub_src = ALUB_IMM;
                c.alu_ctr  = ALU_ADD;
            end
            OPC_OPIMM: begin
                c.ext_op   = EXT_I;
                c.reg_wr   = 1'b1;
                c.alub_src = ALUB_IMM;
                c.alu_ctr  = (f3 == 3'b101) ? {f7[5], f3}
                                            : {1'b0, f3};
            end
            OPC_OP: begin
                c.ext_op   = EXT_R;
                c.reg_wr   = 1'b1;
                c.alub_src = ALUB_RS2;
                c.alu_ctr  = {f7[5], f3};
                if (f7 == F7_BASE) begin
                    ill = 1'b0;
                end else if (f7 == F7_ALT &&
                             (f3 == 3'b000 || f3 == 3'b101)) begin
                    ill = 1'b0;
                end else if (f7 == F7_MULD && ENABLE_M) begin
                    c.md_en   = 1'b1;
                    c.md_op   = f3;
                    c.alu_ctr = ALU_ADD;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_JAL: begin
                c.ext_op   = EXT_J;
                c.reg_wr   = 1'b1;
                c.alua_src = 1'b1;
                c.alub_src = ALUB_4;
                c.branch   = BR_JAL;
            end
            OPC_JALR: begin
                c.ext_op   = EXT_I;
                c.reg_wr   = 1'b1;
                c.alua_src = 1'b1;
                c.alub_src = ALUB_4;
                c.branch   = BR_JALR;
            end
            OPC_BRANCH: begin
                c.ext_op  = EXT_B;
                c.alu_ctr = (f3[2:1] == 2'b11) ? ALU_SLTU
                                               : ALU_SLT;
                unique case (f3)
                    3'b000:  c.branch = BR_EQ;
                    3'b001:  c.branch = BR_NE;
                    3'b100:  c.branch = BR_LT;
                    3'b101:  c.branch = BR_GE;
                    3'b110:  c.branch = BR_LT;
                    3'b111:  c.branch = BR_GE;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                c.ext_op     = EXT_I;
                c.reg_wr     = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alub_src   = ALUB_IMM;
                unique case (f3)
                    3'b000:  c.mem_op = MEM_B;
                    3'b001:  c.mem_op = MEM_H;
                    3'b010:  c.mem_op = MEM_W;
                    3'b100:  c.mem_op = MEM_BU;
                    3'b101:  c.mem_op = MEM_HU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                c.ext_op   = EXT_S;
                c.mem_wr   = 1'b1;
                c.alub_src = ALUB_IMM;
                unique case (f3)
                    3'b000:  c.mem_op = MEM_B;
                    3'b001:  c.mem_op = MEM_H;
                    3'b010:  c.mem_op = MEM_W;
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (inst_i[1:0] != 2'b11) begin
            ill = 1'b1;
        end
        if (ill) begin
            c = '0;
        end
    end

    assign ctrl_o    = c;
    assign illegal_o = ill;
    assign md_en_o   = c.md_en;

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID/EX pipeline register around the control decoder,
// with valid/ready handshake, flush and mul/div interlock.
module ctrl_decode_pipe
    import ctrl_decode_pipe_pkg::*;
#(
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned MD_LAT   = 4,
    parameter int unsigned PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_ExtOp,
    output logic [2:0]      out_Branch,
    output logic [1:0]      out_ALUBSrc,
    output logic [3:0]      out_ALUctr,
    output logic [2:0]      out_MemOp,
    output logic            out_RegWr,
    output logic            out_MemtoReg,
    output logic            out_ALUASrc,
    output logic            out_MemWr,
    output logic            out_md_en,
    output logic [2:0]      out_md_op,
    output logic            out_illegal
);

    localparam int CNT_W = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

    ctrl_t dec_ctrl;
    logic  dec_ill;
    logic  dec_md_en;

    ctrl_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .inst_i    (in_inst),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_ill),
        .md_en_o   (dec_md_en)
    );

    logic            valid_q, valid_d;
    ctrl_t           ctrl_q,  ctrl_d;
    logic            ill_q,   ill_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic [4:0]      rd_q,    rd_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic md_block;
    logic accept;

    assign md_block = (cnt_q != '0) & dec_md_en;
    assign in_ready = (~valid_q | out_ready) & ~md_block;
    assign accept   = in_valid & in_ready & ~flush;

    // Next state: flush wins, then load-on-accept, then drain
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            if (accept) begin
                valid_d = 1'b1;
                ctrl_d  = dec_ctrl;
                ill_d   = dec_ill;
                pc_d    = in_pc;
                rd_d    = in_inst[11:7];
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
            if (accept && dec_md_en) begin
                cnt_d = MD_LOAD;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // ID/EX register and mul/div occupancy counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            pc_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_rd       = rd_q;
    assign out_ExtOp    = ctrl_q.ext_op;
    assign out_Branch   = ctrl_q.branch;
    assign out_ALUBSrc  = ctrl_q.alub_src;
    assign out_ALUctr   = ctrl_q.alu_ctr;
    assign out_MemOp    = ctrl_q.mem_op;
    assign out_RegWr    = ctrl_q.reg_wr;
    assign out_MemtoReg = ctrl_q.mem_to_reg;
    assign out_ALUASrc  = ctrl_q.alua_src;
    assign out_MemWr    = ctrl_q.mem_wr;
    assign out_md_en    = ctrl_q.md_en;
    assign out_md_op    = ctrl_q.md_op;
    assign out_illegal  = ill_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe: decode table,
// handshake stalls, mul/div interlock, flush and reset.
module tb_ctrl_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [2:0]  out_ExtOp, out_Branch, out_MemOp, out_md_op;
    logic [1:0]  out_ALUBSrc;
    logic [3:0]  out_ALUctr;
    logic        out_RegWr, out_MemtoReg, out_ALUASrc, out_MemWr;
    logic        out_md_en, out_illegal;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(
        .ENABLE_M (1'b1),
        .MD_LAT   (4),
        .PC_W     (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_ExtOp    (out_ExtOp),
        .out_Branch   (out_Branch),
        .out_ALUBSrc  (out_ALUBSrc),
        .out_ALUctr   (out_ALUctr),
        .out_MemOp    (out_MemOp),
        .out_RegWr    (out_RegWr),
        .out_MemtoReg (out_MemtoReg),
        .out_ALUASrc  (out_ALUASrc),
        .out_MemWr    (out_MemWr),
        .out_md_en    (out_md_en),
        .out_md_op    (out_md_op),
        .out_illegal  (out_illegal)
    );

    logic [23:0] obs;
    assign obs = {out_illegal, out_ExtOp, out_Branch,
                  out_ALUBSrc, out_ALUctr, out_MemOp,
                  out_RegWr, out_MemtoReg, out_ALUASrc,
                  out_MemWr, out_md_en, out_md_op};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h",
                      tag, got, exp);
    endtask

    function automatic logic [23:0] E(
        input logic       ill,
        input logic [2:0] ext,
        input logic [2:0] br,
        input logic [1:0] ab,
        input logic [3:0] ac,
        input logic [2:0] mo,
        input logic       rw,
        input logic       m2r,
        input logic       aa,
        input logic       mw,
        input logic       md,
        input logic [2:0] mop);
        return {ill, ext, br, ab, ac, mo,
                rw, m2r, aa, mw, md, mop};
    endfunction

    typedef struct packed {
        logic [23:0] e;
        logic [4:0]  rd;
        logic [31:0] pc;
    } sb_t;

    sb_t         q[$];
    logic [23:0] cur_exp = '0;
    logic        hold_prev = 1'b0;
    logic [61:0] snap = '0;
    logic [23:0] E_ILL;

    // Scoreboard: push on accept, pop on EX transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                chk("hold", {out_valid, obs, out_rd, out_pc},
                    {2'b00, snap});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_empty_pop", 1, 0);
                end else begin
                    sb_t h;
                    h = q.pop_front();
                    chk("ctl", obs, h.e);
                    chk("rd", out_rd, h.rd);
                    chk("pc", out_pc, h.pc);
                end
            end else if (out_valid && flush) begin
                if (q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready && !flush)
                q.push_back({cur_exp, in_inst[11:7], in_pc});
            hold_prev = out_valid && !out_ready && !flush;
            snap = {out_valid, obs, out_rd, out_pc};
        end
    end

    task automatic send(input logic [31:0] inst,
                        input logic [23:0] e,
                        input logic [31:0] pc,
                        output int waits);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        cur_exp  = e;
        waits    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready && !flush) break;
            waits++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_ctl"}, obs, 0);
        chk({tag, "_rd"}, out_rd, 0);
        chk({tag, "_pc"}, out_pc, 0);
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;

    logic [31:0] vi[22];
    logic [23:0] ve[22];

    initial begin
        int w;
        logic [23:0] e_addi, e_add, e_mul, e_div, e_lui;
        E_ILL  = E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_addi = E(0, 3'b000, 3'b000, 2'b01, 4'b0000, 3'b000,
                   1, 0, 0, 0, 0, 3'b000);
        e_add  = E(0, 3'b101, 3'b000, 2'b00, 4'b0000, 3'b000,
                   1, 0, 0, 0, 0, 3'b000);
        e_mul  = E(0, 3'b101, 3'b000, 2'b00, 4'b0000, 3'b000,
                   1, 0, 0, 0, 1, 3'b000);
        e_div  = E(0, 3'b101, 3'b000, 2'b00, 4'b0000, 3'b000,
                   1, 0, 0, 0, 1, 3'b100);
        e_lui  = E(0, 3'b001, 3'b000, 2'b01, 4'b1111, 3'b000,
                   1, 0, 0, 0, 0, 3'b000);

        vi[0]  = I_ADDI;       ve[0]  = e_addi;
        vi[1]  = 32'h4020D093; ve[1]  = E(0, 3'b000, 3'b000,
            2'b01, 4'b1101, 3'b000, 1, 0, 0, 0, 0, 3'b000);
        vi[2]  = 32'h00209463; ve[2]  = E(0, 3'b011, 3'b101,
            2'b00, 4'b0010, 3'b000, 0, 0, 0, 0, 0, 3'b000);
        vi[3]  = 32'h0020E463; ve[3]  = E(0, 3'b011, 3'b110,
            2'b00, 4'b0011, 3'b000, 0, 0, 0, 0, 0, 3'b000);
        vi[4]  = 32'h00409183; ve[4]  = E(0, 3'b000, 3'b000,
            2'b01, 4'b0000, 3'b010, 1, 1, 0, 0, 0, 3'b000);
        vi[5]  = 32'h0000B183; ve[5]  = E_ILL;
        vi[6]  = 32'h0000017F; ve[6]  = E_ILL;
        vi[7]  = 32'h00500091; ve[7]  = E_ILL;
        vi[8]  = I_LUI;        ve[8]  = e_lui;
        vi[9]  = 32'h00000317; ve[9]  = E(0, 3'b001, 3'b000,
            2'b01, 4'b0000, 3'b000, 1, 0, 1, 0, 0, 3'b000);
        vi[10] = 32'h008000EF; ve[10] = E(0, 3'b100, 3'b001,
            2'b10, 4'b0000, 3'b000, 1, 0, 1, 0, 0, 3'b000);
        vi[11] = 32'h00008067; ve[11] = E(0, 3'b000, 3'b010,
            2'b10, 4'b0000, 3'b000, 1, 0, 1, 0, 0, 3'b000);
        vi[12] = 32'h0020A423; ve[12] = E(0, 3'b010, 3'b000,
            2'b01, 4'b0000, 3'b000, 0, 0, 0, 1, 0, 3'b000);
        vi[13] = I_ADD;        ve[13] = e_add;
        vi[14] = 32'h402081B3; ve[14] = E(0, 3'b101, 3'b000,
            2'b00, 4'b1000, 3'b000, 1, 0, 0, 0, 0, 3'b000);
        vi[15] = I_MUL;        ve[15] = e_mul;
        vi[16] = I_DIV;        ve[16] = e_div;
        vi[17] = 32'h402091B3; ve[17] = E_ILL;
        vi[18] = 32'h0020A463; ve[18] = E_ILL;
        vi[19] = 32'h0020C423; ve[19] = E_ILL;
        vi[20] = 32'h0000C183; ve[20] = E(0, 3'b000, 3'b000,
            2'b01, 4'b0000, 3'b101, 1, 1, 0, 0, 0, 3'b000);
        vi[21] = 32'h0020D463; ve[21] = E(0, 3'b011, 3'b111,
            2'b00, 4'b0010, 3'b000, 0, 0, 0, 0, 0, 3'b000);

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_idle", in_ready, 1);
        @(posedge clk);
        #1;

        // decode table, back to back, EX always ready
        for (int i = 0; i < 22; i++) begin
            send(vi[i], ve[i], 32'h1000 + 32'(4 * i), w);
            if (i == 0) chk("lat1", out_valid, 1);
            if (ve[i][3] == 1'b0) chk("tput", w, 0);
        end
        idle(6);
        chk("sb_drain1", q.size(), 0);

        // mul/div interlock
        send(I_MUL, e_mul, 32'h2000, w);
        chk("mul_w", w, 0);
        send(I_DIV, e_div, 32'h2004, w);
        chk("div_wait", w, 3);
        send(I_ADD, e_add, 32'h2008, w);
        chk("add_after_div", w, 0);
        idle(6);
        send(I_MUL, e_mul, 32'h2010, w);
        send(I_ADD, e_add, 32'h2014, w);
        chk("add_after_mul", w, 0);
        idle(6);

        // EX stall for 5 cycles, then full-rate release
        out_ready = 1'b0;
        send(I_ADDI, e_addi, 32'h3000, w);
        in_valid = 1'b1;
        in_inst  = I_LUI;
        in_pc    = 32'h3004;
        cur_exp  = e_lui;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rdy", in_ready, 0);
            chk("stall_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        send(I_ADD, e_add, 32'h3008, w);
        chk("rel_tput1", w, 0);
        send(32'h4020D093, ve[1], 32'h300C, w);
        chk("rel_tput2", w, 0);
        idle(6);
        chk("sb_drain2", q.size(), 0);

        // flush while a MUL is held and md_cnt is 2
        out_ready = 1'b0;
        send(I_MUL, e_mul, 32'h4000, w);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = I_ADD;
        in_pc    = 32'h4004;
        cur_exp  = e_add;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_q", q.size(), 0);
        send(I_MUL, e_mul, 32'h4008, w);
        chk("flush_mul", w, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);

        // reset mid-stall drops the held bundle
        out_ready = 1'b0;
        send(I_ADDI, e_addi, 32'h5000, w);
        in_valid = 1'b1;
        in_inst  = I_LUI;
        in_pc    = 32'h5004;
        cur_exp  = e_lui;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("rst_mid");
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
        send(I_ADD, e_add, 32'h6000, w);
        idle(4);
        chk("sb_drain3", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
